fly_formation_ctrl: RTL and testbench

Owns enemy ("fly") state for one wave. It spawns flies one per frame, marches the formation left and right, drops it a row at each screen edge, and retires flies on hit reports. It produces the packed fly_x_flat / fly_y_flat / fly_alive buses consumed directly by the fly sprite drawer. It also reports wave completion and bottom reach to the game FSM.

---
 rtl/fly_formation_ctrl.sv | 179 +++++++++++++++++
 tb/tb_fly_formation_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fly_formation_ctrl.sv
// Enemy formation controller: spawns, marches and retires flies, drives the sprite buses.
// Optional FLY_SPEEDUP_EN shortens the march divisor as the formation thins out.
module fly_pos_lane #(
  parameter int COL       = 0,
  parameter int ROW       = 0,
  parameter int SPACING_X = 48,
  parameter int SPACING_Y = 40,
  parameter int POS_W     = 16
) (
  input  logic [POS_W-1:0] org_x,
  input  logic [POS_W-1:0] org_y,
  output logic [9:0]       x,
  output logic [9:0]       y
);
  logic [POS_W-1:0] sx, sy;
  assign sx = org_x + POS_W'(COL * SPACING_X);
  assign sy = org_y + POS_W'(ROW * SPACING_Y);
  assign x  = sx[9:0];
  assign y  = sy[9:0];
endmodule

module fly_formation_ctrl #(
  parameter int FLY_COUNT = 16,
  parameter int COLS      = 4,
  parameter int ORG_X0    = 160,
  parameter int ORG_Y0    = 40,
  parameter int SPACING_X = 48,
  parameter int SPACING_Y = 40,
  parameter int STEP_X    = 4,
  parameter int DROP_Y    = 16,
  parameter int STEP_DIV  = 8,
  parameter int X_MAX     = 639,
  parameter int Y_LIMIT   = 400,
  localparam int IDX_W    = (FLY_COUNT > 1) ? $clog2(FLY_COUNT) : 1,
  localparam int CNT_W    = $clog2(FLY_COUNT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    hit_valid,
  input  logic [IDX_W-1:0]        hit_idx,
  output logic [10*FLY_COUNT-1:0] fly_x_flat,
  output logic [10*FLY_COUNT-1:0] fly_y_flat,
  output logic [FLY_COUNT-1:0]    fly_alive,
  output logic [CNT_W-1:0]        alive_count,
  output logic                    wave_clear,
  output logic                    reached_bottom
);
  localparam int ROWS   = (FLY_COUNT + COLS - 1) / COLS;
  localparam int FORM_W = (COLS - 1) * SPACING_X + 32;
  localparam int FORM_H = (ROWS - 1) * SPACING_Y + 32;
  localparam int TICK_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int POS_W  = 16;

  typedef enum logic [2:0] {S_IDLE, S_SPAWN, S_MARCH, S_CLEAR, S_HALT} state_t;

  state_t               state, state_n;
  logic [POS_W-1:0]     org_x, org_x_n, org_y, org_y_n;
  logic                 dir_left, dir_left_n;
  logic [FLY_COUNT-1:0] alive_n;
  logic [TICK_W-1:0]    tick_cnt, tick_cnt_n;
  logic [IDX_W-1:0]     spawn_idx, spawn_idx_n;
  logic [CNT_W-1:0]     pop;
  logic                 hit_ok;
  int                   div_eff;

  always_comb begin
    pop = '0;
    for (int i = 0; i < FLY_COUNT; i++) pop = pop + CNT_W'(fly_alive[i]);
  end

  always_comb begin
    div_eff = STEP_DIV;
`ifdef FLY_SPEEDUP_EN
    if (int'(alive_count) > FLY_COUNT / 2)      div_eff = STEP_DIV;
    else if (int'(alive_count) > FLY_COUNT / 4) div_eff = (STEP_DIV / 2 > 1) ? STEP_DIV / 2 : 1;
    else                                        div_eff = 1;
`endif
  end

  // Unspawned flies read as dead, so this also rejects hits on them.
  assign hit_ok = hit_valid && (int'(hit_idx) < FLY_COUNT) && fly_alive[hit_idx] &&
                  (state == S_SPAWN || state == S_MARCH);

  always_comb begin
    state_n     = state;
    org_x_n     = org_x;
    org_y_n     = org_y;
    dir_left_n  = dir_left;
    alive_n     = fly_alive;
    tick_cnt_n  = tick_cnt;
    spawn_idx_n = spawn_idx;
    if (hit_ok) alive_n[hit_idx] = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_n     = S_SPAWN;
          org_x_n     = POS_W'(ORG_X0);
          org_y_n     = POS_W'(ORG_Y0);
          dir_left_n  = 1'b0;
          alive_n     = '0;
          spawn_idx_n = '0;
          tick_cnt_n  = '0;
        end
      end
      S_SPAWN: begin
        if (frame_tick) begin
          alive_n[spawn_idx] = 1'b1;
          if (int'(spawn_idx) == FLY_COUNT - 1) begin
            state_n    = S_MARCH;
            tick_cnt_n = '0;
          end else begin
            spawn_idx_n = spawn_idx + IDX_W'(1);
          end
        end
      end
      S_MARCH: begin
        if (alive_count == '0 && fly_alive == '0) begin
          state_n = S_CLEAR;
        end else if (frame_tick) begin
          // >= so a divisor that shrinks below the running count steps at once
          if (int'(tick_cnt) >= div_eff - 1) begin
            tick_cnt_n = '0;
            if (dir_left ? (int'(org_x) < STEP_X)
                         : (int'(org_x) + STEP_X + FORM_W - 1 > X_MAX)) begin
              org_y_n    = org_y + POS_W'(DROP_Y);
              dir_left_n = ~dir_left;
              if (int'(org_y) + DROP_Y + FORM_H > Y_LIMIT) state_n = S_HALT;
            end else if (dir_left) begin
              org_x_n = org_x - POS_W'(STEP_X);
            end else begin
              org_x_n = org_x + POS_W'(STEP_X);
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end
      end
      S_CLEAR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      org_x          <= POS_W'(ORG_X0);
      org_y          <= POS_W'(ORG_Y0);
      dir_left       <= 1'b0;
      fly_alive      <= '0;
      alive_count    <= '0;
      tick_cnt       <= '0;
      spawn_idx      <= '0;
      wave_clear     <= 1'b0;
      reached_bottom <= 1'b0;
    end else begin
      state          <= state_n;
      org_x          <= org_x_n;
      org_y          <= org_y_n;
      dir_left       <= dir_left_n;
      fly_alive      <= alive_n;
      alive_count    <= pop;
      tick_cnt       <= tick_cnt_n;
      spawn_idx      <= spawn_idx_n;
      wave_clear     <= (state_n == S_CLEAR);
      reached_bottom <= (state_n == S_HALT);
    end
  end

  for (genvar i = 0; i < FLY_COUNT; i++) begin : g_lane
    fly_pos_lane #(
      .COL(i % COLS), .ROW(i / COLS), .SPACING_X(SPACING_X), .SPACING_Y(SPACING_Y), .POS_W(POS_W)
    ) u_lane (
      .org_x(org_x), .org_y(org_y),
      .x(fly_x_flat[i*10 +: 10]), .y(fly_y_flat[i*10 +: 10])
    );
  end
endmodule

// File: tb/tb_fly_formation_ctrl.sv
// Directed bench for fly_formation_ctrl: default instance plus a low Y_LIMIT instance on shared stimulus.
module tb_fly_formation_ctrl;
  localparam int N = 16;
`ifdef FLY_SPEEDUP_EN
  localparam int X_AFTER1 = 456, X_AFTER8 = 428;
`else
  localparam int X_AFTER1 = 460, X_AFTER8 = 456;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic frame_tick = 1'b0, start = 1'b0, hit_valid = 1'b0;
  logic [3:0] hit_idx = '0;
  logic [10*N-1:0] xa, ya, xb, yb;
  logic [N-1:0] alive_a, alive_b;
  logic [4:0] cnt_a, cnt_b;
  logic wc_a, wc_b, rb_a, rb_b;
  int n_tests = 0, n_fail = 0;

  fly_formation_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .fly_x_flat(xa), .fly_y_flat(ya), .fly_alive(alive_a),
    .alive_count(cnt_a), .wave_clear(wc_a), .reached_bottom(rb_a)
  );
  fly_formation_ctrl #(.Y_LIMIT(200)) dut_b (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .fly_x_flat(xb), .fly_y_flat(yb), .fly_alive(alive_b),
    .alive_count(cnt_b), .wave_clear(wc_b), .reached_bottom(rb_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    frame_tick = 1'b1;
    repeat (n) cyc();
    frame_tick = 1'b0;
  endtask

  task automatic hit(input int idx);
    hit_valid = 1'b1; hit_idx = 4'(idx);
    cyc();
    hit_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  function automatic int px(input logic [10*N-1:0] f, input int i);
    return int'(f[i*10 +: 10]);
  endfunction

  initial begin
    int wc_cycles;
    repeat (3) cyc();
    chk("rst_alive", alive_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_wc", wc_a, 0);
    chk("rst_rb", rb_a, 0);
    chk("rst_x0", px(xa, 0), 160);
    chk("rst_y0", px(ya, 0), 40);
    rst = 1'b0; cyc();

    // partial spawn, early hit on an unspawned fly, then async reset
    pulse_start();
    ticks(5);
    hit(9);
    chk("spawn5_alive", alive_a, 16'h001F);
    #2 rst = 1'b1; #1;
    chk("async_alive", alive_a, 0);
    chk("async_count", cnt_a, 0);
    cyc(); rst = 1'b0; cyc();

    // full spawn with a same-cycle hit on the fly being spawned
    pulse_start();
    ticks(9);
    frame_tick = 1'b1; hit_valid = 1'b1; hit_idx = 4'd9;
    cyc();
    frame_tick = 1'b0; hit_valid = 1'b0;
    chk("spawn_hit9_alive", alive_a, 16'h03FF);
    ticks(6);
    chk("spawn_full", alive_a, 16'hFFFF);
    cyc();
    chk("spawn_count", cnt_a, 16);
    chk("fly0_x", px(xa, 0), 160);
    chk("fly5_x", px(xa, 5), 208);
    chk("fly5_y", px(ya, 5), 80);
    chk("fly15_x", px(xa, 15), 304);
    chk("fly15_y", px(ya, 15), 160);

    // march right to the edge
    ticks(7);
    chk("march7_x", px(xa, 0), 160);
    ticks(1);
    chk("march8_x", px(xa, 0), 164);
    chk("march8_y", px(ya, 0), 40);
    ticks(600);
    chk("step76_x", px(xa, 0), 464);
    chk("step76_y", px(ya, 0), 40);
    ticks(8);
    chk("drop_x", px(xa, 0), 464);
    chk("drop_y", px(ya, 0), 56);
    chk("drop_rb", rb_a, 0);
    chk("b_drop_y", px(yb, 0), 56);
    chk("b_halt_rb", rb_b, 1);
    ticks(8);
    chk("left_x", px(xa, 0), 460);
    chk("b_frozen_x", px(xb, 0), 464);

    // hits in MARCH; the halted instance must ignore them
    hit(3);
    chk("hit3_alive", alive_a, 16'hFFF7);
    chk("b_hit3_ignored", alive_b, 16'hFFFF);
    chk("hit3_count_lag", cnt_a, 16);
    cyc();
    chk("hit3_count", cnt_a, 15);
    hit(3); cyc();
    chk("rehit3_alive", alive_a, 16'hFFF7);
    chk("rehit3_count", cnt_a, 15);
    for (int i = 0; i < 12; i++) if (i != 3) hit(i);
    cyc();
    chk("four_left_alive", alive_a, 16'hF000);
    chk("four_left_count", cnt_a, 4);

    // march divisor with 4 alive
    ticks(1);
    chk("thin_tick1_x", px(xa, 0), X_AFTER1);
    ticks(7);
    chk("thin_tick8_x", px(xa, 0), X_AFTER8);

    // clear the wave
    for (int i = 12; i < 16; i++) hit(i);
    wc_cycles = 0;
    for (int c = 0; c < 8; c++) begin
      if (wc_a) wc_cycles++;
      cyc();
    end
    chk("wave_clear_cycles", wc_cycles, 1);
    chk("clear_alive", alive_a, 0);
    chk("clear_count", cnt_a, 0);
    ticks(10);
    chk("idle_frozen_x", px(xa, 0), X_AFTER8);
    chk("idle_frozen_y", px(ya, 0), 56);
    chk("b_still_halt", rb_b, 1);
    chk("b_alive_held", alive_b, 16'hFFFF);

    // restart from HALT
    pulse_start();
    chk("b_restart_rb", rb_b, 0);
    chk("b_restart_x", px(xb, 0), 160);
    chk("b_restart_y", px(yb, 0), 40);
    chk("b_restart_alive", alive_b, 0);
    chk("a_restart_x", px(xa, 0), 160);
    ticks(1);
    chk("b_respawn0", alive_b, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
